instr_executor: RTL and testbench
=================================

# instr_executor

Execution stage directly downstream of the instruction register. On a start command it walks the register file from a start address, fetches each stored instruction word, evaluates it with a signed-arithmetic ALU, and emits one 64-bit result per instruction over a valid/ready handshake. It drives the register's `read_pointer` and consumes its `instruction_word`, so the register needs no other read-side master.

## Interface
Parameters:
- `NUM_ENTRIES`, 32: instruction register depth; must be a power of two; pointer width is `$clog2(NUM_ENTRIES)`.

Ports:
- `clk`  in  1  single clock for the block.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `first_ptr`  in  `address_t`  address of the first instruction, captured on `start`.
- `num_instr`  in  `$clog2(NUM_ENTRIES)+1`  number of instructions to run, captured on `start`.
- `read_pointer`  out  `address_t`  read address to the instruction register.
- `instruction_word`  in  `instruction_t`  combinational read data from the register at `read_pointer`.
- `result_valid`  out  1  `result` is valid.
- `result_ready`  in  1  consumer accepts `result`.
- `result`  out  `result_t`  signed 64-bit ALU result.
- `result_addr`  out  `address_t`  address that produced `result`.
- `result_err`  out  1  illegal opcode or divide-by-zero for this result.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a sequence completes.

## Operation
- States: IDLE, FETCH, EXEC, OUT, DONE.
- IDLE: if `start`, capture `first_ptr` into `read_pointer` and `num_instr` into the remaining counter. Go to FETCH, or to DONE if `num_instr` is 0.
- FETCH: `read_pointer` is stable. Register `instruction_word` at the clock edge. Go to EXEC.
- EXEC: the ALU evaluates the captured word. Register `result`, `result_err` and `result_addr`. Go to OUT.
- OUT: `result_valid` is 1, and `result`, `result_err` and `result_addr` are held stable until `result_ready`.
- On the handshake in OUT: decrement the remaining counter and increment `read_pointer`. Go to FETCH if the counter is nonzero, otherwise to DONE.
- DONE: pulse `done` for one cycle, then return to IDLE.
- Opcode behaviour (operands are signed 32-bit, result is signed 64-bit; all evaluation is in full width, so there is no overflow):
  - ZERO: 0.
  - PASSA: `op_a` sign-extended.
  - PASSB: `op_b` sign-extended.
  - ADD, SUB, MULT: computed in full 64-bit width.
  - DIV, MOD: see Configuration.
- `op_b`=0 for DIV or MOD: `result`=0, `result_err`=1.
- Any undefined opcode encoding: `result`=0, `result_err`=1.
- `read_pointer` wraps from `NUM_ENTRIES-1` to 0.
- `num_instr` values above `NUM_ENTRIES` are legal: the walk wraps and re-reads entries.
- `start` outside IDLE is ignored; there is no queueing.

## Timing
- Reset values: `read_pointer`=0, `result`=0, `result_addr`=0, `result_err`=0, `result_valid`=0, `busy`=0, `done`=0; state is IDLE.
- `reset_n` asserted mid-sequence aborts immediately and asynchronously. No partial result or `done` appears after release.
- `busy` rises in the cycle after `start` is accepted.
- Latency from `start` to the first `result_valid` is 3 cycles (FETCH, EXEC, then OUT visible).
- Per-instruction throughput is 3 cycles when `result_ready` is held high.
- `done` asserts in the cycle after the final handshake.
- `result_valid` never drops without a handshake, and the result fields never change while valid and not ready.
- `instruction_word` is sampled only in FETCH. Writes to the register during EXEC or OUT do not affect the current result.

## Configuration
- Macro: `INSTR_EXEC_DIV_EN`.
- Defined: DIV gives `op_a / op_b` (truncating toward zero) and MOD gives `op_a % op_b` (sign follows `op_a`), both computed combinationally in EXEC.
- Undefined: no divider is built. DIV and MOD behave as illegal opcodes (`result`=0, `result_err`=1). All other behaviour is unchanged.

## Structure
- Shared package `instr_register_pkg` holds `opcode_t`, `operand_t` (signed 32-bit), `address_t` and `instruction_t`.
- This block adds `result_t` (signed 64-bit) and `exec_state_t` (IDLE, FETCH, EXEC, OUT, DONE) to the same package.
- One combinational sub-module, `instr_alu`, takes an `instruction_t` and returns `result_t` plus an error flag. The divider is guarded by `INSTR_EXEC_DIV_EN`.
- The state machine, counter, pointer and output registers live in `instr_executor`.

## Test plan
- Reset: assert `reset_n`=0 -> all outputs 0. Release, then `start` with `first_ptr`=0, `num_instr`=3, entries ADD(5,7), SUB(3,10), MULT(-4,6), `result_ready`=1 -> results 12, -7, -24 at addresses 0, 1, 2, `done` one cycle after the third handshake.
- Backpressure: hold `result_ready`=0 for 10 cycles during the first OUT -> `result_valid` stays 1 and `result`/`result_addr` are unchanged. Raise `result_ready` -> sequence continues.
- Wrap: `first_ptr`=30, `num_instr`=4 -> `result_addr` sequence 30, 31, 0, 1.
- Divide: DIV(-17,5), MOD(-17,5), DIV(9,0) -> with macro: -3 (err 0), -2 (err 0), 0 (err 1). Without macro: all three give 0 with err 1.
- Edge cases: `num_instr`=0 -> `done` pulses 2 cycles after `start` with no `result_valid`. `start` while busy is ignored.
- Mid-sequence reset: pulse `reset_n` low during EXEC of the second instruction -> outputs clear immediately, and `result_valid` and `done` stay 0 until the next `start`.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its execution stage.
// Opcodes 8..15 are unassigned and decode as illegal.
package instr_register_pkg;

    localparam int REG_DEPTH = 32;
    localparam int PTR_W     = $clog2(REG_DEPTH);

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [PTR_W-1:0]   address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef logic signed [63:0] result_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        OUT,
        DONE
    } exec_state_t;

endpackage

// File: rtl/instr_executor_alu.sv
// Combinational signed ALU for one instruction word.
// The divider exists only when INSTR_EXEC_DIV_EN is defined.
module instr_alu
    import instr_register_pkg::*;
(
    input  instruction_t instr,
    output result_t      res,
    output logic         err
);

    result_t a;
    result_t b;

    always_comb begin
        a   = {{32{instr.op_a[31]}}, instr.op_a};
        b   = {{32{instr.op_b[31]}}, instr.op_b};
        res = '0;
        err = 1'b0;
        unique case (instr.opc)
            ZERO:  res = '0;
            PASSA: res = a;
            PASSB: res = b;
            ADD:   res = a + b;
            SUB:   res = a - b;
            MULT:  res = a * b;
`ifdef INSTR_EXEC_DIV_EN
            DIV: begin
                if (b == '0) err = 1'b1;
                else         res = a / b;
            end
            MOD: begin
                if (b == '0) err = 1'b1;
                else         res = a % b;
            end
`endif
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_executor.sv
// Walks the instruction register, evaluates each word, and streams results.
// Optional divider: define INSTR_EXEC_DIV_EN.
module instr_executor
    import instr_register_pkg::*;
#(
    parameter int NUM_ENTRIES = REG_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  address_t                     first_ptr,
    input  logic [$clog2(NUM_ENTRIES):0] num_instr,
    output address_t                     read_pointer,
    input  instruction_t                 instruction_word,
    output logic                         result_valid,
    input  logic                         result_ready,
    output result_t                      result,
    output address_t                     result_addr,
    output logic                         result_err,
    output logic                         busy,
    output logic                         done
);

    exec_state_t                  state;
    exec_state_t                  state_n;
    logic [$clog2(NUM_ENTRIES):0] remaining;
    instruction_t                 iw;
    result_t                      alu_res;
    logic                         alu_err;

    instr_alu u_alu (
        .instr (iw),
        .res   (alu_res),
        .err   (alu_err)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (start) state_n = (num_instr == '0) ? DONE : FETCH;
            FETCH: state_n = EXEC;
            EXEC:  state_n = OUT;
            OUT:   if (result_ready) state_n = (remaining == 1) ? DONE : FETCH;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Pointer wraps naturally: NUM_ENTRIES is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_pointer <= '0;
            remaining    <= '0;
            iw           <= '0;
            result       <= '0;
            result_addr  <= '0;
            result_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        read_pointer <= first_ptr;
                        remaining    <= num_instr;
                    end
                end
                FETCH: iw <= instruction_word;
                EXEC: begin
                    result      <= alu_res;
                    result_err  <= alu_err;
                    result_addr <= read_pointer;
                end
                OUT: begin
                    if (result_ready) begin
                        remaining    <= remaining - 1'b1;
                        read_pointer <= read_pointer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_valid = (state == OUT);
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

endmodule

// File: tb/tb_instr_executor.sv
// Randomized self-checking bench for instr_executor against a queue-based model.
module tb_instr_executor;
    import instr_register_pkg::*;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         result_ready = 1'b0;
    address_t     first_ptr = '0;
    logic [5:0]   num_instr = '0;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         result_valid;
    result_t      result;
    address_t     result_addr;
    logic         result_err;
    logic         busy;
    logic         done;

    instruction_t mem [N];
    int tests = 0;
    int fails = 0;

    assign instruction_word = mem[read_pointer];

    instr_executor #(.NUM_ENTRIES(N)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .first_ptr        (first_ptr),
        .num_instr        (num_instr),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .result           (result),
        .result_addr      (result_addr),
        .result_err       (result_err),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    function automatic instruction_t mk(input opcode_t o, input int a, input int b);
        instruction_t w;
        w.opc  = o;
        w.op_a = a;
        w.op_b = b;
        return w;
    endfunction

    function automatic instruction_t rnd_instr();
        instruction_t w;
        w.opc  = opcode_t'(4'($urandom_range(0, 11)));
        w.op_a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) - 10 : int'($urandom);
        w.op_b = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom);
        return w;
    endfunction

    // Reference semantics in plain 64-bit integer arithmetic.
    function automatic void model(input instruction_t w, output longint r, output bit e);
        int     ia = w.op_a;
        int     ib = w.op_b;
        longint a  = ia;
        longint b  = ib;
        r = 0;
        e = 0;
        case (w.opc)
            ZERO:  r = 0;
            PASSA: r = a;
            PASSB: r = b;
            ADD:   r = a + b;
            SUB:   r = a - b;
            MULT:  r = a * b;
`ifdef INSTR_EXEC_DIV_EN
            DIV: if (b == 0) e = 1; else r = a / b;
            MOD: if (b == 0) e = 1; else r = a % b;
`else
            DIV: e = 1;
            MOD: e = 1;
`endif
            default: e = 1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_seq(input int first, input int n, input int rdy_pct,
                           input int stall, input bit poke, input bit scribble);
        longint er[$];
        bit     ee[$];
        int     ea[$];
        longint r;
        bit     e;
        logic [63:0] hold_r;
        logic [63:0] hold_a;
        logic [63:0] hold_e;
        int  cyc = 1;
        int  first_v = -1;
        int  last_hs = -1;
        int  stall_left = stall;
        bit  stalled = 0;
        bit  got_done = 0;
        bit  rdy;
        for (int i = 0; i < n; i++) begin
            model(mem[(first + i) % N], r, e);
            er.push_back(r);
            ee.push_back(e);
            ea.push_back((first + i) % N);
        end
        @(negedge clk);
        first_ptr    = address_t'(first);
        num_instr    = 6'(n);
        start        = 1'b1;
        result_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("busy_rise", busy, 1);
        while (cyc < n * 40 + 40 && !got_done) begin
            if (poke && cyc == 2) begin
                start     = 1'b1;
                first_ptr = address_t'(first + 5);
                num_instr = 6'd1;
            end else begin
                start = 1'b0;
            end
            if (result_valid) begin
                if (first_v < 0) begin
                    first_v = cyc;
                    chk("latency", cyc, 3);
                end
                if (!stalled) begin
                    chk("addr", result_addr, ea.size() ? ea[0] : -1);
                    chk("result", result, er.size() ? er[0] : 64'hx);
                    chk("err", result_err, ee.size() ? ee[0] : 1'bx);
                    if (rdy_pct == 100 && stall == 0 && last_hs >= 0)
                        chk("throughput", cyc - last_hs, 3);
                    hold_r = result;
                    hold_a = result_addr;
                    hold_e = result_err;
                end else begin
                    chk("hold_result", result, hold_r);
                    chk("hold_addr", result_addr, hold_a);
                    chk("hold_err", result_err, hold_e);
                end
                if (scribble && n <= N) mem[result_addr] = rnd_instr();
                if (stall_left > 0) begin
                    rdy = 0;
                    stall_left--;
                end else begin
                    rdy = ($urandom_range(1, 100) <= rdy_pct);
                end
                result_ready = rdy;
                if (rdy) begin
                    if (er.size()) begin
                        void'(er.pop_front());
                        void'(ee.pop_front());
                        void'(ea.pop_front());
                    end
                    stalled = 0;
                    last_hs = cyc;
                end else begin
                    stalled = 1;
                end
            end else begin
                result_ready = 1'($urandom_range(0, 1));
            end
            if (done) begin
                got_done = 1;
                chk("done_q_empty", er.size(), 0);
                if (n > 0) chk("done_timing", cyc, last_hs + 1);
                else       chk("done_zero", (cyc <= 2), 1);
            end
            if (!got_done) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        chk("done_seen", got_done, 1);
        if (n == 0) chk("no_valid", (first_v < 0), 1);
        @(negedge clk);
        result_ready = 1'b0;
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        bit quiet;
        for (int i = 0; i < N; i++) mem[i] = rnd_instr();

        #12;
        chk("rst_valid", result_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_addr", result_addr, 0);
        chk("rst_err", result_err, 0);
        chk("rst_ptr", read_pointer, 0);
        @(negedge clk);
        reset_n = 1'b1;

        mem[0] = mk(ADD, 5, 7);
        mem[1] = mk(SUB, 3, 10);
        mem[2] = mk(MULT, -4, 6);
        run_seq(0, 3, 100, 0, 0, 0);
        run_seq(0, 3, 100, 10, 0, 0);

        run_seq(30, 4, 100, 0, 0, 0);

        mem[5] = mk(DIV, -17, 5);
        mem[6] = mk(MOD, -17, 5);
        mem[7] = mk(DIV, 9, 0);
        run_seq(5, 3, 100, 0, 0, 0);

        run_seq(0, 0, 100, 0, 0, 0);

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) mem[i] = rnd_instr();
            run_seq($urandom_range(0, N - 1), $urandom_range(1, 40), 60, 0,
                    (k % 3) == 0, k[0]);
        end

        // Abort during EXEC of the second instruction.
        mem[0] = mk(ADD, 5, 7);
        mem[1] = mk(SUB, 3, 10);
        mem[2] = mk(MULT, -4, 6);
        @(negedge clk);
        first_ptr    = '0;
        num_instr    = 6'd3;
        start        = 1'b1;
        result_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_abort_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_valid", result_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        chk("abort_ptr", read_pointer, 0);
        chk("abort_err", result_err, 0);
        @(negedge clk);
        reset_n = 1'b1;
        quiet = 1;
        repeat (10) begin
            @(negedge clk);
            if (result_valid || done || busy) quiet = 0;
        end
        chk("abort_quiet", quiet, 1);
        run_seq(0, 3, 100, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
